// File: rtl/usb_desc_streamer.sv
// usb_desc_streamer: answers GET_DESCRIPTOR data stages for EP0 by streaming
// bytes from a synchronous descriptor ROM. It splits the stream into packets
// of MAX_PKT bytes and requests a zero-length packet when the host asked for
// more than the descriptor holds and the transfer ends on a packet boundary.
module usb_desc_streamer #(
    parameter int MAX_PKT   = 8,
    parameter int ROM_AW    = 8,
    parameter int DEV_BASE  = 0,
    parameter int DEV_LEN   = 18,
    parameter int CFG_BASE  = 18,
    parameter int CFG_LEN   = 32,
    parameter int STR0_BASE = 50,
    parameter int STR0_LEN  = 4
) (
    input  logic              clk48,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        desc_type,
    input  logic [7:0]        desc_idx,
    input  logic [15:0]       w_length,
    input  logic              abort,
    output logic              busy,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              zlp_valid,
    input  logic              zlp_ready,
    output logic              done,
    output logic              stall
);

    localparam logic [ROM_AW-1:0] DEV_BASE_A  = ROM_AW'(DEV_BASE);
    localparam logic [ROM_AW-1:0] CFG_BASE_A  = ROM_AW'(CFG_BASE);
    localparam logic [ROM_AW-1:0] STR0_BASE_A = ROM_AW'(STR0_BASE);
    localparam logic [15:0]       DEV_LEN_W   = 16'(DEV_LEN);
    localparam logic [15:0]       CFG_LEN_W   = 16'(CFG_LEN);
    localparam logic [15:0]       STR0_LEN_W  = 16'(STR0_LEN);
    // MAX_PKT is a power of two, so "mod MAX_PKT" is a mask
    localparam logic [15:0]       PKT_MASK    = 16'(MAX_PKT - 1);

    typedef enum logic [2:0] {
        IDLE, LOOKUP, FETCH, LOAD, STREAM, ZLP
    } state_t;

    state_t            r_state;
    logic [7:0]        r_type;
    logic [7:0]        r_idx;
    logic [15:0]       r_wlen;
    logic [15:0]       r_len;
    logic [15:0]       r_sent;
    logic [ROM_AW-1:0] r_base;
    logic [ROM_AW-1:0] r_rom_addr;
    logic [7:0]        r_out_data;
    logic              r_out_valid;
    logic              r_out_last;
    logic              r_zlp_valid;
    logic              r_done;
    logic              r_stall;
    logic              r_busy;

    logic              w_hit;
    logic [ROM_AW-1:0] w_base;
    logic [15:0]       w_dlen;
    logic [15:0]       w_len;
    logic [15:0]       w_sent_nx;
    logic              w_zlp_due;

    // Decode the latched request into a ROM region; unknown requests miss
    always_comb begin
        w_hit  = 1'b0;
        w_base = '0;
        w_dlen = '0;
        case (r_type)
            8'd1: begin
                w_hit  = 1'b1;
                w_base = DEV_BASE_A;
                w_dlen = DEV_LEN_W;
            end
            8'd2: if (r_idx == 8'd0) begin
                w_hit  = 1'b1;
                w_base = CFG_BASE_A;
                w_dlen = CFG_LEN_W;
            end
            8'd3: if (r_idx == 8'd0) begin
                w_hit  = 1'b1;
                w_base = STR0_BASE_A;
                w_dlen = STR0_LEN_W;
            end
            default: ;
        endcase
    end

    // Never send more than the host asked for
    assign w_len     = (w_dlen < r_wlen) ? w_dlen : r_wlen;
    assign w_sent_nx = r_sent + 16'd1;
    // A short-but-packet-aligned reply needs a ZLP so the host sees the end
    assign w_zlp_due = (r_len < r_wlen) && ((r_len & PKT_MASK) == 16'd0);

    // Transfer FSM with registered outputs; abort overrides everything
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_type      <= '0;
            r_idx       <= '0;
            r_wlen      <= '0;
            r_len       <= '0;
            r_sent      <= '0;
            r_base      <= '0;
            r_rom_addr  <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_zlp_valid <= 1'b0;
            r_done      <= 1'b0;
            r_stall     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_stall <= 1'b0;
            if (abort) begin
                r_state     <= IDLE;
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
                r_zlp_valid <= 1'b0;
                r_busy      <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: if (start) begin
                        r_type  <= desc_type;
                        r_idx   <= desc_idx;
                        r_wlen  <= w_length;
                        r_busy  <= 1'b1;
                        r_state <= LOOKUP;
                    end
                    LOOKUP: begin
                        if (!w_hit) begin
                            r_stall <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_base     <= w_base;
                            r_len      <= w_len;
                            r_sent     <= '0;
                            r_rom_addr <= w_base;
                            if (w_len == 16'd0) begin
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= IDLE;
                            end else begin
                                r_state <= FETCH;
                            end
                        end
                    end
                    // rom_addr is stable this cycle; ROM answers next cycle
                    FETCH: r_state <= LOAD;
                    LOAD: begin
                        r_out_data  <= rom_data;
                        r_out_valid <= 1'b1;
                        r_out_last  <= ((w_sent_nx & PKT_MASK) == 16'd0) ||
                                       (w_sent_nx == r_len);
                        r_state     <= STREAM;
                    end
                    STREAM: if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_sent      <= w_sent_nx;
                        if (w_sent_nx < r_len) begin
                            r_rom_addr <= r_base + w_sent_nx[ROM_AW-1:0];
                            r_state    <= FETCH;
                        end else if (w_zlp_due) begin
                            r_zlp_valid <= 1'b1;
                            r_state     <= ZLP;
                        end else begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                    ZLP: if (zlp_ready) begin
                        r_zlp_valid <= 1'b0;
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign busy      = r_busy;
    assign rom_addr  = r_rom_addr;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign zlp_valid = r_zlp_valid;
    assign done      = r_done;
    assign stall     = r_stall;

endmodule

// File: tb/tb_usb_desc_streamer.sv
// Directed bench for usb_desc_streamer with a registered ROM model.
module tb_usb_desc_streamer;

    logic        clk48 = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  desc_type;
    logic [7:0]  desc_idx;
    logic [15:0] w_length;
    logic        abort;
    logic        busy;
    logic [7:0]  rom_addr;
    logic [7:0]  rom_data;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        zlp_valid;
    logic        zlp_ready;
    logic        done;
    logic        stall;

    int checks = 0;
    int errors = 0;

    logic [7:0] rom [0:255];

    always #5 clk48 = ~clk48;

    always @(posedge clk48) rom_data <= rom[rom_addr];

    usb_desc_streamer dut (
        .clk48    (clk48),
        .rst_n    (rst_n),
        .start    (start),
        .desc_type(desc_type),
        .desc_idx (desc_idx),
        .w_length (w_length),
        .abort    (abort),
        .busy     (busy),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .zlp_valid(zlp_valid),
        .zlp_ready(zlp_ready),
        .done     (done),
        .stall    (stall)
    );

    typedef struct {
        logic [7:0]  typ;
        logic [7:0]  idx;
        logic [15:0] wl;
        bit          bp;    // random backpressure on out_ready/zlp_ready
        bit          poke;  // pulse a second start mid-transfer
        int          n;     // expected byte count
        int          base;  // expected ROM base
        bit          zlp;   // expected ZLP
        bit          stl;   // expected stall
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic run_xfer(input vec_t v, input string nm);
        int   nb = 0, ndone = 0, nstall = 0, nzlp = 0, stall_cyc = -1;
        int   cyc, novl = 0, nunst = 0, stray = 0;
        bit   hold = 0, fin = 0, exp_last;
        logic [7:0] hdata = '0;
        @(negedge clk48);
        desc_type = v.typ; desc_idx = v.idx; w_length = v.wl; start = 1'b1;
        @(negedge clk48);
        start = 1'b0;
        cyc = 1;
        chk({nm, "_busy_lookup"}, busy, 1);
        while (!fin && cyc < 3000) begin
            if (v.poke && cyc == 10) begin
                start = 1'b1; desc_type = 8'd3; desc_idx = 8'd0;
            end else begin
                start = 1'b0;
            end
            if (stall) begin nstall++; stall_cyc = cyc; end
            if (done) ndone++;
            if (out_valid && zlp_valid) novl++;
            if (out_valid && hold && out_data !== hdata) nunst++;
            out_ready = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
            zlp_ready = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                if (nb < v.n) begin
                    exp_last = ((nb + 1) % 8 == 0) || (nb + 1 == v.n);
                    chk($sformatf("%s_data%0d", nm, nb), out_data, rom[v.base + nb]);
                    chk($sformatf("%s_last%0d", nm, nb), out_last, exp_last);
                end
                nb++;
            end
            hold  = out_valid && !out_ready;
            hdata = out_data;
            if (zlp_valid && zlp_ready) nzlp++;
            if (done || stall) begin
                fin = 1'b1;
            end else begin
                @(negedge clk48);
                cyc++;
            end
        end
        start = 1'b0;
        chk({nm, "_finished"}, fin, 1);
        chk({nm, "_busy_end"}, busy, 0);
        out_ready = 1'b1;
        zlp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk48);
            if (done || stall || out_valid || zlp_valid || busy) stray++;
        end
        chk({nm, "_bytes"}, nb, v.n);
        chk({nm, "_done"}, ndone, v.stl ? 0 : 1);
        chk({nm, "_stall"}, nstall, v.stl ? 1 : 0);
        chk({nm, "_zlp"}, nzlp, v.zlp ? 1 : 0);
        chk({nm, "_overlap"}, novl, 0);
        chk({nm, "_stable"}, nunst, 0);
        chk({nm, "_stray"}, stray, 0);
        if (v.stl) chk({nm, "_stall_cyc"}, stall_cyc, 2);
    endtask

    initial begin
        int nb, cyc, stray;
        vec_t v;

        for (int i = 0; i < 256; i++) rom[i] = 8'((i * 37 + 11) & 255);

        vecs[0]  = '{8'd1, 8'd0, 16'd64,  1'b0, 1'b0, 18, 0,  1'b0, 1'b0};
        vecs[1]  = '{8'd1, 8'd5, 16'd8,   1'b0, 1'b0, 8,  0,  1'b0, 1'b0};
        vecs[2]  = '{8'd2, 8'd0, 16'd255, 1'b0, 1'b0, 32, 18, 1'b1, 1'b0};
        vecs[3]  = '{8'd6, 8'd0, 16'd64,  1'b0, 1'b0, 0,  0,  1'b0, 1'b1};
        vecs[4]  = '{8'd3, 8'd1, 16'd255, 1'b0, 1'b0, 0,  0,  1'b0, 1'b1};
        vecs[5]  = '{8'd3, 8'd0, 16'd255, 1'b0, 1'b0, 4,  50, 1'b0, 1'b0};
        vecs[6]  = '{8'd1, 8'd0, 16'd0,   1'b0, 1'b0, 0,  0,  1'b0, 1'b0};
        vecs[7]  = '{8'd2, 8'd0, 16'd32,  1'b0, 1'b0, 32, 18, 1'b0, 1'b0};
        vecs[8]  = '{8'd2, 8'd0, 16'd40,  1'b1, 1'b0, 32, 18, 1'b1, 1'b0};
        vecs[9]  = '{8'd2, 8'd0, 16'd255, 1'b1, 1'b1, 32, 18, 1'b1, 1'b0};
        vecs[10] = '{8'd1, 8'd0, 16'd12,  1'b1, 1'b0, 12, 0,  1'b0, 1'b0};
        vecs[11] = '{8'd2, 8'd1, 16'd64,  1'b0, 1'b0, 0,  0,  1'b0, 1'b1};
        vecs[12] = '{8'd2, 8'd0, 16'd16,  1'b0, 1'b0, 16, 18, 1'b0, 1'b0};

        rst_n = 1'b0; start = 1'b0; desc_type = '0; desc_idx = '0;
        w_length = '0; abort = 1'b0; out_ready = 1'b0; zlp_ready = 1'b0;

        #23;
        chk("reset_busy", busy, 0);
        chk("reset_outs", {out_valid, out_last, zlp_valid, done, stall}, 0);
        chk("reset_data", out_data, 0);
        chk("reset_addr", rom_addr, 0);
        @(negedge clk48);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) run_xfer(vecs[i], $sformatf("vec%0d", i));

        // Abort while byte 6 is presented and the sink is ready
        @(negedge clk48);
        desc_type = 8'd2; desc_idx = 8'd0; w_length = 16'd255; start = 1'b1;
        @(negedge clk48);
        start = 1'b0; out_ready = 1'b1; nb = 0; cyc = 0;
        while (nb < 5 && cyc < 200) begin
            if (out_valid) nb++;
            @(negedge clk48);
            cyc++;
        end
        out_ready = 1'b0;
        while (!out_valid && cyc < 200) begin
            @(negedge clk48);
            cyc++;
        end
        chk("abort_byte6_presented", out_valid, 1);
        abort = 1'b1; out_ready = 1'b1;
        @(negedge clk48);
        abort = 1'b0;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        stray = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk48);
            if (done || stall || out_valid || zlp_valid || busy) stray++;
        end
        chk("abort_quiet", stray, 0);
        run_xfer(vecs[2], "after_abort");

        // Reset while byte 10 is waiting on backpressure
        @(negedge clk48);
        desc_type = 8'd2; desc_idx = 8'd0; w_length = 16'd255; start = 1'b1;
        @(negedge clk48);
        start = 1'b0; out_ready = 1'b1; nb = 0; cyc = 0;
        while (nb < 9 && cyc < 300) begin
            if (out_valid) nb++;
            @(negedge clk48);
            cyc++;
        end
        out_ready = 1'b0;
        while (!out_valid && cyc < 300) begin
            @(negedge clk48);
            cyc++;
        end
        chk("rst_byte10_data", out_data, rom[18 + 9]);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_zlp_done_stall", {zlp_valid, done, stall}, 0);
        @(negedge clk48);
        rst_n = 1'b1;
        v = vecs[5];
        run_xfer(v, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
